decode_pipe: RTL and testbench

- Parametrised successor of the current decode stage for the pipelined processor.
- Splits InstrD into fields using a parameterised layout and generates control.
- Holds the general register file, with the top register aliased to PCPlus8D and optional same-cycle writeback bypass.
- Detects load-use hazards, drives StallD to fetch, and registers everything into the ID/EX pipeline register feeding execute.

---
 rtl/decode_pipe.sv | 158 +++++++++++++++
 tb/tb_decode_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Decode stage: field split, control decode, register file with PC+8 alias, load-use stall, ID/EX register.
// Define DECODE_BYPASS_EN to make same-cycle writeback data visible to reads (write-through).
module decode_pipe #(
  parameter int N      = 24,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      InstrD,
  input  logic [N-1:0]      PCPlus8D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WA3W,
  input  logic [N-1:0]      ResultW,
  input  logic              FlushE,
  output logic              StallD,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic              IllegalE,
  output logic [2:0]        ALUControlE,
  output logic [N-1:0]      RD1E,
  output logic [N-1:0]      RD2E,
  output logic [N-1:0]      ExtImmE,
  output logic [REG_AW-1:0] WA3E,
  output logic [REG_AW-1:0] RA1E,
  output logic [REG_AW-1:0] RA2E
);

  localparam int REG_COUNT = 2 ** REG_AW;
  localparam int IMMW      = N - 4 - 3 * REG_AW;
  localparam logic [REG_AW-1:0] PC_REG = REG_AW'(REG_COUNT - 1);

  typedef struct packed {
    logic              regWrite;
    logic              memtoReg;
    logic              memWrite;
    logic              branch;
    logic              aluSrc;
    logic              illegal;
    logic [2:0]        aluControl;
    logic [N-1:0]      rd1;
    logic [N-1:0]      rd2;
    logic [N-1:0]      extImm;
    logic [REG_AW-1:0] wa3;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
  } idExT;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd, rn, rm, ra1D, ra2D;
  logic [IMMW-1:0]   imm;
  logic [N-1:0]      extImmD, rd1D, rd2D;
  logic              regWriteD, memtoRegD, memWriteD, branchD, aluSrcD, illegalD;
  logic              use1, use2;
  logic [2:0]        aluControlD;
  logic [N-1:0]      regFile [REG_COUNT];
  idExT              idExD, idExQ;

  assign opcode  = InstrD[N-1 -: 4];
  assign rd      = InstrD[N-5 -: REG_AW];
  assign rn      = InstrD[N-5-REG_AW -: REG_AW];
  assign rm      = InstrD[N-5-2*REG_AW -: REG_AW];
  assign imm     = InstrD[IMMW-1:0];
  assign extImmD = {{(N-IMMW){imm[IMMW-1]}}, imm};

  // Unused opcodes leave every control low and only raise the illegal flag.
  always_comb begin
    regWriteD   = 1'b0;
    memtoRegD   = 1'b0;
    memWriteD   = 1'b0;
    branchD     = 1'b0;
    aluSrcD     = 1'b0;
    illegalD    = 1'b0;
    aluControlD = 3'b000;
    use1        = 1'b0;
    use2        = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        regWriteD   = 1'b1;
        aluControlD = {1'b0, opcode[1:0]};
        use1        = 1'b1;
        use2        = 1'b1;
      end
      4'h4: begin regWriteD = 1'b1; aluSrcD = 1'b1; use1 = 1'b1; end
      4'h5: begin
        regWriteD   = 1'b1;
        aluSrcD     = 1'b1;
        aluControlD = 3'b001;
        use1        = 1'b1;
      end
      4'h8: begin memtoRegD = 1'b1; regWriteD = 1'b1; aluSrcD = 1'b1; use1 = 1'b1; end
      4'h9: begin memWriteD = 1'b1; aluSrcD = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      4'hC: begin branchD = 1'b1; aluSrcD = 1'b1; use1 = 1'b1; end
      4'hF: ;
      default: illegalD = 1'b1;
    endcase
  end

  // Branches read the PC+8 alias; stores read their data register from the Rd field.
  assign ra1D = branchD ? PC_REG : rn;
  assign ra2D = memWriteD ? rd : rm;

  always_comb begin
    rd1D = regFile[ra1D];
    rd2D = regFile[ra2D];
`ifdef DECODE_BYPASS_EN
    if (RegWriteW && (WA3W != PC_REG)) begin
      if (ra1D == WA3W) rd1D = ResultW;
      if (ra2D == WA3W) rd2D = ResultW;
    end
`endif
    if (ra1D == PC_REG) rd1D = PCPlus8D;
    if (ra2D == PC_REG) rd2D = PCPlus8D;
  end

  // The top register is never stored: it always aliases PCPlus8D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regFile[i] <= '0;
    end else if (RegWriteW && (WA3W != PC_REG)) begin
      regFile[WA3W] <= ResultW;
    end
  end

  assign StallD = idExQ.memtoReg & idExQ.regWrite &
                  ((use1 & (ra1D == idExQ.wa3)) | (use2 & (ra2D == idExQ.wa3)));

  always_comb begin
    idExD = '{regWrite: regWriteD, memtoReg: memtoRegD, memWrite: memWriteD,
              branch: branchD, aluSrc: aluSrcD, illegal: illegalD,
              aluControl: aluControlD, rd1: rd1D, rd2: rd2D, extImm: extImmD,
              wa3: rd, ra1: ra1D, ra2: ra2D};
  end

  // Flush and stall both insert an all-zero bubble; a single bubble covers both at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 idExQ <= '0;
    else if (FlushE | StallD) idExQ <= '0;
    else                     idExQ <= idExD;
  end

  assign RegWriteE   = idExQ.regWrite;
  assign MemtoRegE   = idExQ.memtoReg;
  assign MemWriteE   = idExQ.memWrite;
  assign BranchE     = idExQ.branch;
  assign ALUSrcE     = idExQ.aluSrc;
  assign IllegalE    = idExQ.illegal;
  assign ALUControlE = idExQ.aluControl;
  assign RD1E        = idExQ.rd1;
  assign RD2E        = idExQ.rd2;
  assign ExtImmE     = idExQ.extImm;
  assign WA3E        = idExQ.wa3;
  assign RA1E        = idExQ.ra1;
  assign RA2E        = idExQ.ra2;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed plan scenarios then randomized instructions
// checked against an instruction-level reference model (honours DECODE_BYPASS_EN).
module tb_decode_pipe;
  localparam int N = 24;
  localparam int REG_AW = 4;
  localparam logic [N-1:0] NOP = 24'hF00000;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] InstrD, PCPlus8D, ResultW;
  logic RegWriteW, FlushE;
  logic [REG_AW-1:0] WA3W;
  logic StallD, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, IllegalE;
  logic [2:0] ALUControlE;
  logic [N-1:0] RD1E, RD2E, ExtImmE;
  logic [REG_AW-1:0] WA3E, RA1E, RA2E;

  typedef struct packed {
    logic regWrite, memtoReg, memWrite, branch, aluSrc, illegal;
    logic [2:0] aluCtl;
    logic [N-1:0] rd1, rd2, extImm;
    logic [REG_AW-1:0] wa3, ra1, ra2;
  } eVecT;
  typedef struct { int cyc; eVecT v; } eItemT;
  typedef struct { int cyc; logic stall; } sItemT;

  eItemT eQ[$];
  sItemT sQ[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [N-1:0] modelRegs [16];
  eVecT modelE, pendingE;
  logic pendWe;
  logic [3:0] pendWa;
  logic [N-1:0] pendRes;

  decode_pipe #(.N(N), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW), .FlushE(FlushE),
    .StallD(StallD), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .IllegalE(IllegalE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ExtImmE(ExtImmE), .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic eVecT dutVec();
    return {RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, IllegalE, ALUControlE,
            RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Register read as the programmer sees it: R15 is PC+8, writes land next cycle unless bypassed.
  function automatic logic [N-1:0] modelRead(input logic [3:0] a);
    if (a == 4'd15) return PCPlus8D;
`ifdef DECODE_BYPASS_EN
    if (RegWriteW && a == WA3W) return ResultW;
`endif
    return modelRegs[a];
  endfunction

  task automatic applyStimulus(input logic [N-1:0] instr, input logic we = 1'b0,
                               input logic [3:0] wa = 4'd0, input logic [N-1:0] res = '0,
                               input logic flush = 1'b0, input logic [N-1:0] pc = 24'h000100);
    int opc;
    eVecT d;
    logic use1, use2, stall;
    logic signed [7:0] imm8;
    @(posedge clk);
    #1;
    if (pendWe && pendWa != 4'd15) modelRegs[pendWa] = pendRes;
    modelE = pendingE;
    InstrD = instr; RegWriteW = we; WA3W = wa; ResultW = res; FlushE = flush; PCPlus8D = pc;
    opc = int'(instr[23:20]);
    imm8 = instr[7:0];
    d = '0;
    d.illegal  = !(opc inside {[0:5], 8, 9, 12, 15});
    d.regWrite = (opc <= 5) || (opc == 8);
    d.memtoReg = (opc == 8);
    d.memWrite = (opc == 9);
    d.branch   = (opc == 12);
    d.aluSrc   = opc inside {4, 5, 8, 9, 12};
    d.aluCtl   = (opc <= 3) ? 3'(opc) : ((opc == 5) ? 3'd1 : 3'd0);
    d.ra1      = (opc == 12) ? 4'd15 : instr[15:12];
    d.ra2      = (opc == 9) ? instr[19:16] : instr[11:8];
    d.wa3      = instr[19:16];
    d.rd1      = modelRead(d.ra1);
    d.rd2      = modelRead(d.ra2);
    d.extImm   = N'(int'(imm8));
    use1  = (opc <= 5) || (opc inside {8, 9, 12});
    use2  = (opc <= 3) || (opc == 9);
    stall = modelE.memtoReg && modelE.regWrite &&
            ((use1 && d.ra1 == modelE.wa3) || (use2 && d.ra2 == modelE.wa3));
    sQ.push_back('{cyc, stall});
    pendingE = (flush || stall) ? '0 : d;
    eQ.push_back('{cyc + 1, pendingE});
    pendWe = we; pendWa = wa; pendRes = res;
  endtask

  task automatic doReset();
    #1 rst = 1'b1;
    sQ.delete();
    eQ.delete();
    #1;
    checkOutput("rstStallD", 128'(StallD), 128'(0));
    checkOutput("rstEOutputs", 128'(dutVec()), 128'(0));
    InstrD = NOP; RegWriteW = 1'b0; FlushE = 1'b0;
    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
    modelE = '0; pendingE = '0; pendWe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the entry due this cycle.
  always @(negedge clk) begin
    sItemT s;
    eItemT e;
    while (sQ.size() > 0 && sQ[0].cyc <= cyc) begin
      s = sQ.pop_front();
      if (s.cyc == cyc) checkOutput("StallD", 128'(StallD), 128'(s.stall));
      else checkOutput("sbStallCycle", 128'(s.cyc), 128'(cyc));
    end
    while (eQ.size() > 0 && eQ[0].cyc <= cyc) begin
      e = eQ.pop_front();
      if (e.cyc == cyc) checkOutput("idExVector", 128'(dutVec()), 128'(e.v));
      else checkOutput("sbEStageCycle", 128'(e.cyc), 128'(cyc));
    end
  end

  initial begin
    logic [3:0] opcList [12];
    logic [3:0] opc, fRd, fRn, fRm;
    int waitCycles;
    opcList = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hF, 4'h6, 4'h7};
    rst = 1'b1; InstrD = NOP; PCPlus8D = 24'h000100; RegWriteW = 1'b0; WA3W = '0;
    ResultW = '0; FlushE = 1'b0;
    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
    modelE = '0; pendingE = '0; pendWe = 1'b0; pendWa = '0; pendRes = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("initEOutputs", 128'(dutVec()), 128'(0));
    checkOutput("initStallD", 128'(StallD), 128'(0));

    $display("[TB] register ADD with prior write");
    applyStimulus(NOP, 1'b1, 4'd3, 24'h00ABCD);
    applyStimulus(24'h023300);
    applyStimulus(NOP, 1'b1, 4'd5, 24'h000777);
    checkOutput("addRD1E", 128'(RD1E), 128'(24'h00ABCD));
    checkOutput("addRD2E", 128'(RD2E), 128'(24'h00ABCD));
    checkOutput("addALUControlE", 128'(ALUControlE), 128'(3'b000));
    checkOutput("addRegWriteE", 128'(RegWriteE), 128'(1));
    checkOutput("addWA3E", 128'(WA3E), 128'(2));
    checkOutput("addALUSrcE", 128'(ALUSrcE), 128'(0));

    $display("[TB] SUBI with same-cycle writeback");
    applyStimulus(24'h5650FF, 1'b1, 4'd5, 24'h000123);
    applyStimulus(NOP);
`ifdef DECODE_BYPASS_EN
    checkOutput("subiRD1E", 128'(RD1E), 128'(24'h000123));
`else
    checkOutput("subiRD1E", 128'(RD1E), 128'(24'h000777));
`endif
    checkOutput("subiExtImmE", 128'(ExtImmE), 128'(24'hFFFFFF));
    checkOutput("subiALUControlE", 128'(ALUControlE), 128'(3'b001));
    checkOutput("subiALUSrcE", 128'(ALUSrcE), 128'(1));

    $display("[TB] load-use hazard");
    applyStimulus(24'h841004);
    applyStimulus(24'h074400);
    #1 checkOutput("loadUseStallD", 128'(StallD), 128'(1));
    applyStimulus(24'h074400);
    checkOutput("bubbleRegWriteE", 128'(RegWriteE), 128'(0));
    #1 checkOutput("stallReleased", 128'(StallD), 128'(0));
    applyStimulus(NOP);
    checkOutput("afterStallRegWriteE", 128'(RegWriteE), 128'(1));
    checkOutput("afterStallWA3E", 128'(WA3E), 128'(7));

    $display("[TB] branch then flush");
    applyStimulus(24'hC00010, 1'b0, 4'd0, '0, 1'b0, 24'h000100);
    applyStimulus(NOP, 1'b0, 4'd0, '0, 1'b1, 24'h000100);
    checkOutput("branchRD1E", 128'(RD1E), 128'(24'h000100));
    checkOutput("branchExtImmE", 128'(ExtImmE), 128'(24'h000010));
    checkOutput("branchBranchE", 128'(BranchE), 128'(1));
    checkOutput("branchRegWriteE", 128'(RegWriteE), 128'(0));
    applyStimulus(NOP);
    checkOutput("flushBranchE", 128'(BranchE), 128'(0));
    checkOutput("flushRD1E", 128'(RD1E), 128'(0));

    $display("[TB] illegal opcode and R15 write");
    applyStimulus(24'h712300, 1'b1, 4'd15, 24'h00DEAD, 1'b0, 24'h000200);
    applyStimulus(24'hC00010, 1'b0, 4'd0, '0, 1'b0, 24'h000200);
    checkOutput("illegalIllegalE", 128'(IllegalE), 128'(1));
    checkOutput("illegalRegWriteE", 128'(RegWriteE), 128'(0));
    checkOutput("illegalMemWriteE", 128'(MemWriteE), 128'(0));
    checkOutput("illegalBranchE", 128'(BranchE), 128'(0));
    applyStimulus(NOP);
    checkOutput("r15AliasRD1E", 128'(RD1E), 128'(24'h000200));

    $display("[TB] reset mid-stream");
    applyStimulus(24'h841004);
    applyStimulus(24'h074400);
    #1 checkOutput("preResetStallD", 128'(StallD), 128'(1));
    doReset();
    applyStimulus(24'h023300);
    applyStimulus(NOP);
    checkOutput("postResetR3", 128'(RD1E), 128'(0));

    $display("[TB] randomized instructions");
    for (int i = 0; i < 400; i++) begin
      opc = opcList[$urandom_range(0, 11)];
      fRd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      fRn = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      fRm = 4'($urandom_range(0, 3));
      applyStimulus({opc, fRd, fRn, fRm, 8'($urandom())}, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                    N'($urandom()), ($urandom_range(0, 7) == 0), N'($urandom()));
    end
    applyStimulus(NOP);

    waitCycles = 0;
    while ((eQ.size() > 0 || sQ.size() > 0) && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    @(negedge clk);
    #1;
    checkOutput("scoreboardDrained", 128'(eQ.size() + sQ.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
